mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
// - Memory-side responder for the CPU's memory request interface, driven by the control unit's
//   mem_rw / mem_size / address (PC during fetch, MAR otherwise).
// - Serves byte, half and word reads and writes against a byte-wide synchronous RAM, one byte per
//   cycle, little-endian. Returns zero-extended read data; sign extension stays in the CPU datapath.
// PARAMETERS
// - DEPTH         256  RAM size in bytes; power of two; byte address = req_addr[AW-1:0], AW=$clog2(DEPTH)
// - STRICT_ALIGN  0    1: misaligned half/word requests are rejected with resp_err; 0: served byte-serially
// PORTS
// - clk         in   1   single clock, all state on posedge
// - rst         in   1   synchronous, active-high reset
// - req_valid   in   1   request present this cycle
// - req_ready   out  1   responder idle; request accepted when req_valid & req_ready
// - req_rw      in   1   1 = write, 0 = read (same sense as mem_rw)
// - req_size    in   2   0 none, 1 byte, 2 half, 3 word (same encoding as mem_size)
// - req_addr    in   32  byte address of the lowest byte
// - req_wdata   in   32  write data; bits [8n-1:0] used for n bytes
// - resp_valid  out  1   one-cycle pulse: access complete
// - resp_rdata  out  32  read data, zero-extended, valid while resp_valid on reads; 0 on writes/errors
// - resp_err    out  1   valid with resp_valid: misaligned under STRICT_ALIGN
// BEHAVIOUR
// - Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, byte counter=0.
//   RAM contents are not cleared.
// - States: IDLE -> ACCESS -> (read only) DRAIN -> RESP -> IDLE; error path IDLE -> RESP.
// - IDLE: req_ready=1. Accept on req_valid. Latch rw, size, addr, wdata. n = size (1, 2 or 4 bytes; size 3 -> n=4).
//   - size==0 accepted as a no-op: go to RESP, no RAM access, resp_err=0.
// - Misalignment: half with addr[0]!=0, word with addr[1:0]!=0.
//   - STRICT_ALIGN=1: go to RESP with resp_err=1, no RAM access.
//   - STRICT_ALIGN=0: served normally.
// - ACCESS: one byte k per cycle, k=0..n-1, at RAM address (addr+k) mod DEPTH (wrap-around, no error).
//   - Write: byte k = wdata[8k+7:8k], committed at end of cycle.
//   - Read: address issued; RAM data returns next cycle and is placed in rdata[8k+7:8k].
// - DRAIN (reads only): one cycle to capture the final byte.
// - RESP: resp_valid=1 for exactly one cycle, req_ready=0; next state IDLE.
// - Latency, accept cycle T0:
//   - write: resp_valid in T(n+1)
//   - read: resp_valid in T(n+2)
//   - error / no-op: resp_valid in T1
// - Back-to-back: next request can be accepted in the cycle after RESP.
// - req_valid and inputs while not IDLE are ignored; latched copies are used throughout.
// - Read-after-write to the same byte always returns the new value: accesses are serialized, no bypass needed.
// - rst mid-operation: return to IDLE next edge, no resp_valid; bytes already written stay written,
//   remaining bytes are not written.
// - resp_rdata holds its value until the next RESP; it is cleared to 0 on a write, error or no-op response.
// STRUCTURE
// - Shared header MemConstants.vh (`include, alongside IDConstants.vh):
//   - MSIZE_NONE/BYTE/HALF/WORD = 0/1/2/3
//   - state encodings IDLE/ACCESS/DRAIN/RESP
// - Sub-module byte_ram (DEPTH x 8): one port, synchronous write, registered read (1-cycle latency),
//   inputs we/addr/wdata, output rdata.
// - Top level holds the FSM, 2-bit byte counter, address incrementer (AW-bit wrap),
//   write-lane mux and read-assembly register.
// TESTING
// - DEPTH=256, STRICT_ALIGN=0.
//   - Word write 0xDEADBEEF @0x10 -> resp_valid in T5.
//   - Byte read @0x10 -> 0x000000EF in T3; byte read @0x13 -> 0x000000DE.
//   - Half read @0x12 -> 0x0000DEAD.
// - Wrap-around: word write 0x11223344 @0xFE -> bytes 0x44@0xFE, 0x33@0xFF, 0x22@0x00, 0x11@0x01;
//   word read @0xFE -> 0x11223344.
// - STRICT_ALIGN=1: half read @0x11 -> resp_valid=1 with resp_err=1 in T1, RAM unchanged.
//   Aligned word read @0x10 is unaffected.
// - size=0 request -> resp_valid in T1, resp_err=0, resp_rdata=0, RAM unchanged.
// - req_valid held high with changing addr/wdata during ACCESS -> ignored; exactly one resp_valid per accept.
// - rst asserted in T2 of word write 0xAABBCCDD @0x20 (prior contents 0):
//   - expect no resp_valid and req_ready=1 after reset
//   - byte @0x20=0xDD, @0x21=0x00
//   - a subsequent read works normally

Source files
------------

// File: rtl/mem_responder_pkg.sv
// ============================================================================
//  Module      : mem_responder_pkg
//  Description : Shared encodings for the memory responder: access sizes,
//                FSM states and small request-decoding helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_responder_pkg;

    // Access size encoding, identical to the control unit's mem_size
    localparam logic [1:0] c_MSIZE_NONE = 2'd0;
    localparam logic [1:0] c_MSIZE_BYTE = 2'd1;
    localparam logic [1:0] c_MSIZE_HALF = 2'd2;
    localparam logic [1:0] c_MSIZE_WORD = 2'd3;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_DRAIN  = 2'd2;
    localparam logic [1:0] c_ST_RESP   = 2'd3;

    // Index of the final byte lane for a given size (n-1)
    function automatic logic [1:0] last_byte_idx(input logic [1:0] size);
        logic [1:0] idx;
        case (size)
            c_MSIZE_BYTE: idx = 2'd0;
            c_MSIZE_HALF: idx = 2'd1;
            default:      idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            c_MSIZE_HALF: mis = addr_lo[0];
            c_MSIZE_WORD: mis = |addr_lo;
            default:      mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_responder_byte_ram.sv
// ============================================================================
//  Module      : mem_responder_byte_ram
//  Description : Single-port DEPTH x 8 RAM, synchronous write, registered read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder_byte_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Read returns the pre-write contents when addressing the byte being written
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
//  Module      : mem_responder
//  Description : Byte-serial memory responder for the CPU request interface;
//                little-endian byte/half/word access to a byte-wide RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH        = 256,
    parameter bit STRICT_ALIGN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;

    logic          r_rw;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_err;
    logic [1:0]    r_cnt;
    logic [1:0]    r_last;
    logic          r_rd_pend;
    logic [1:0]    r_rd_lane;
    logic [31:0]   r_asm;
    logic [31:0]   r_resp_rdata;

    logic          w_accept;
    logic          w_req_mis;
    logic          w_req_skip;
    logic          w_ram_we;
    logic          w_ram_re;
    logic [AW-1:0] w_ram_addr;
    logic [7:0]    w_ram_wdata;
    logic [7:0]    w_ram_rdata;
    logic [31:0]   w_asm_merged;
    logic          w_unused_addr;

    assign w_accept      = req_valid && (r_state == c_ST_IDLE);
    assign w_req_mis     = STRICT_ALIGN && is_misaligned(req_size, req_addr[1:0]);
    assign w_req_skip    = (req_size == c_MSIZE_NONE) || w_req_mis;
    assign w_unused_addr = ^req_addr[31:AW];

    // Byte addresses wrap within the RAM rather than faulting
    assign w_ram_addr  = r_addr + {{(AW-2){1'b0}}, r_cnt};
    assign w_ram_wdata = r_wdata[{r_cnt, 3'b000} +: 8];
    assign w_ram_we    = (r_state == c_ST_ACCESS) && r_rw && !rst;
    assign w_ram_re    = (r_state == c_ST_ACCESS) && !r_rw;

    mem_responder_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_req_skip ? c_ST_RESP : c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: begin
                if (r_cnt == r_last) begin
                    w_next_state = r_rw ? c_ST_RESP : c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: w_next_state = c_ST_RESP;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready  = (r_state == c_ST_IDLE);
        resp_valid = (r_state == c_ST_RESP);
        resp_err   = (r_state == c_ST_RESP) && r_err;
        resp_rdata = r_resp_rdata;
    end

    // Read data for byte k arrives the cycle after its address is issued
    always_comb begin
        w_asm_merged = r_asm;
        if (r_rd_pend) begin
            w_asm_merged[{r_rd_lane, 3'b000} +: 8] = w_ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_err        <= 1'b0;
            r_cnt        <= 2'd0;
            r_last       <= 2'd0;
            r_rd_pend    <= 1'b0;
            r_rd_lane    <= 2'd0;
            r_asm        <= '0;
            r_resp_rdata <= '0;
        end else begin
            r_rd_pend <= w_ram_re;
            r_rd_lane <= r_cnt;
            r_asm     <= w_asm_merged;

            if (w_accept) begin
                r_rw    <= req_rw;
                r_addr  <= req_addr[AW-1:0];
                r_wdata <= req_wdata;
                r_err   <= w_req_mis;
                r_last  <= last_byte_idx(req_size);
                r_cnt   <= 2'd0;
                r_asm   <= '0;
            end

            if ((r_state == c_ST_ACCESS) && (r_cnt != r_last)) begin
                r_cnt <= r_cnt + 2'd1;
            end

            // Published data only changes when a response is about to be presented
            if ((w_next_state == c_ST_RESP) && (r_state != c_ST_RESP)) begin
                r_resp_rdata <= (r_state == c_ST_DRAIN) ? w_asm_merged : 32'd0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Directed vector bench driving a lenient and a strict-alignment
//                responder with identical requests.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

    typedef struct {
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          hold;
        int          lat;
        logic [31:0] rdata;
        int          s_lat;
        logic [31:0] s_rdata;
        logic        s_err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_rw;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        req_ready,   s_req_ready;
    logic        resp_valid,  s_resp_valid;
    logic [31:0] resp_rdata,  s_resp_rdata;
    logic        resp_err,    s_resp_err;

    int          n_checks;
    int          n_errors;
    logic [31:0] prev_a;
    logic [31:0] prev_b;
    vec_t        vecs[$];

    mem_responder #(.DEPTH(256), .STRICT_ALIGN(1'b0)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    mem_responder #(.DEPTH(256), .STRICT_ALIGN(1'b1)) u_strict (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (s_req_ready),
        .req_rw     (req_rw),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (s_resp_valid),
        .resp_rdata (s_resp_rdata),
        .resp_err   (s_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rw, input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit hold, input int lat,
                                input logic [31:0] rdata, input int s_lat,
                                input logic [31:0] s_rdata, input logic s_err);
        vec_t v;
        v.rw = rw; v.size = size; v.addr = addr; v.wdata = wdata; v.hold = hold;
        v.lat = lat; v.rdata = rdata; v.s_lat = s_lat; v.s_rdata = s_rdata; v.s_err = s_err;
        return v;
    endfunction

    // Present one request in the cycle after the previous response and time both responses
    task automatic apply(input int idx, input vec_t v);
        int          la, lb, extra;
        logic [31:0] ra, rb;
        logic        ea, eb;
        bit          hold_a, hold_b;
        la = 0; lb = 0; extra = 0; ra = '0; rb = '0; ea = 1'b0; eb = 1'b0;
        hold_a = 1'b1; hold_b = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("v%0d idle_status", idx),
            {28'd0, req_ready, resp_valid, s_req_ready, s_resp_valid}, 32'h0000_000A);
        req_valid = 1'b1; req_rw = v.rw; req_size = v.size; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk); #1;
        if (!v.hold) req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (resp_valid) begin
                if (la == 0) begin la = c; ra = resp_rdata; ea = resp_err; end
                else extra++;
            end else if (la == 0 && resp_rdata !== prev_a) hold_a = 1'b0;
            if (s_resp_valid) begin
                if (lb == 0) begin lb = c; rb = s_resp_rdata; eb = s_resp_err; end
                else extra++;
            end else if (lb == 0 && s_resp_rdata !== prev_b) hold_b = 1'b0;
            if (la != 0 && lb != 0) break;
            if (v.hold) begin
                req_rw = $urandom_range(0, 1) == 1; req_size = 2'($urandom_range(0, 3));
                req_addr = $urandom; req_wdata = $urandom;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk($sformatf("v%0d latency", idx),      32'(la), 32'(v.lat));
        chk($sformatf("v%0d rdata", idx),        ra, v.rdata);
        chk($sformatf("v%0d err", idx),          {31'd0, ea}, 32'd0);
        chk($sformatf("v%0d strict_latency", idx), 32'(lb), 32'(v.s_lat));
        chk($sformatf("v%0d strict_rdata", idx), rb, v.s_rdata);
        chk($sformatf("v%0d strict_err", idx),   {31'd0, eb}, {31'd0, v.s_err});
        chk($sformatf("v%0d rdata_held", idx),   {30'd0, hold_a, hold_b}, 32'd3);
        chk($sformatf("v%0d extra_pulses", idx), 32'(extra), 32'd0);
        prev_a = v.rdata;
        prev_b = v.s_rdata;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; prev_a = '0; prev_b = '0;
        rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_size = 2'd0;
        req_addr = '0; req_wdata = '0;

        //             rw    size   addr       wdata          hold lat rdata          slat srdata         serr
        vecs.push_back(mk(1'b1, 2'd3, 32'h20, 32'h0000_0000, 0, 5, 32'h0,          5, 32'h0,          1'b0));
        vecs.push_back(mk(1'b1, 2'd3, 32'h10, 32'hDEAD_BEEF, 0, 5, 32'h0,          5, 32'h0,          1'b0));
        vecs.push_back(mk(1'b0, 2'd1, 32'h10, 32'h0,         0, 3, 32'h0000_00EF, 3, 32'h0000_00EF, 1'b0));
        vecs.push_back(mk(1'b0, 2'd1, 32'h13, 32'h0,         0, 3, 32'h0000_00DE, 3, 32'h0000_00DE, 1'b0));
        vecs.push_back(mk(1'b0, 2'd2, 32'h12, 32'h0,         0, 4, 32'h0000_DEAD, 4, 32'h0000_DEAD, 1'b0));
        vecs.push_back(mk(1'b0, 2'd2, 32'h11, 32'h0,         0, 4, 32'h0000_ADBE, 1, 32'h0,          1'b1));
        vecs.push_back(mk(1'b0, 2'd3, 32'h10, 32'h0,         0, 6, 32'hDEAD_BEEF, 6, 32'hDEAD_BEEF, 1'b0));
        vecs.push_back(mk(1'b1, 2'd3, 32'hFC, 32'h0,         0, 5, 32'h0,          5, 32'h0,          1'b0));
        vecs.push_back(mk(1'b1, 2'd3, 32'h00, 32'h0,         0, 5, 32'h0,          5, 32'h0,          1'b0));
        vecs.push_back(mk(1'b1, 2'd3, 32'hFE, 32'h1122_3344, 0, 5, 32'h0,          1, 32'h0,          1'b1));
        vecs.push_back(mk(1'b0, 2'd1, 32'hFE, 32'h0,         0, 3, 32'h0000_0044, 3, 32'h0,          1'b0));
        vecs.push_back(mk(1'b0, 2'd1, 32'hFF, 32'h0,         0, 3, 32'h0000_0033, 3, 32'h0,          1'b0));
        vecs.push_back(mk(1'b0, 2'd1, 32'h00, 32'h0,         0, 3, 32'h0000_0022, 3, 32'h0,          1'b0));
        vecs.push_back(mk(1'b0, 2'd1, 32'h01, 32'h0,         0, 3, 32'h0000_0011, 3, 32'h0,          1'b0));
        vecs.push_back(mk(1'b0, 2'd3, 32'hFE, 32'h0,         0, 6, 32'h1122_3344, 1, 32'h0,          1'b1));
        vecs.push_back(mk(1'b0, 2'd2, 32'hFE, 32'h0,         0, 4, 32'h0000_3344, 4, 32'h0,          1'b0));
        vecs.push_back(mk(1'b1, 2'd0, 32'h10, 32'hFFFF_FFFF, 0, 1, 32'h0,          1, 32'h0,          1'b0));
        vecs.push_back(mk(1'b0, 2'd3, 32'h10, 32'h0,         0, 6, 32'hDEAD_BEEF, 6, 32'hDEAD_BEEF, 1'b0));
        vecs.push_back(mk(1'b1, 2'd1, 32'h40, 32'h0000_005A, 0, 2, 32'h0,          2, 32'h0,          1'b0));
        vecs.push_back(mk(1'b1, 2'd1, 32'h41, 32'hFFFF_FF77, 0, 2, 32'h0,          2, 32'h0,          1'b0));
        vecs.push_back(mk(1'b0, 2'd2, 32'h40, 32'h0,         0, 4, 32'h0000_775A, 4, 32'h0000_775A, 1'b0));
        vecs.push_back(mk(1'b1, 2'd3, 32'h50, 32'hCAFE_F00D, 1, 5, 32'h0,          5, 32'h0,          1'b0));
        vecs.push_back(mk(1'b0, 2'd3, 32'h50, 32'h0,         0, 6, 32'hCAFE_F00D, 6, 32'hCAFE_F00D, 1'b0));
        vecs.push_back(mk(1'b1, 2'd2, 32'h31, 32'h0000_BEEF, 0, 3, 32'h0,          1, 32'h0,          1'b1));
        vecs.push_back(mk(1'b0, 2'd2, 32'h31, 32'h0,         0, 4, 32'h0000_BEEF, 1, 32'h0,          1'b1));

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_status", {28'd0, req_ready, resp_valid, resp_err, s_req_ready}, 32'h0000_0009);
        chk("reset_rdata", resp_rdata, 32'h0);
        chk("reset_strict", {30'd0, s_resp_valid, s_resp_err}, 32'h0);

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // Reset in the second access cycle of a word write: only byte 0 lands
        @(posedge clk); #1;
        req_valid = 1'b1; req_rw = 1'b1; req_size = 2'd3; req_addr = 32'h20; req_wdata = 32'hAABB_CCDD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midrst_no_resp", {30'd0, resp_valid, s_resp_valid}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_status", {28'd0, req_ready, resp_valid, s_req_ready, s_resp_valid}, 32'h0000_000A);
        chk("midrst_rdata", resp_rdata, 32'h0);
        prev_a = '0; prev_b = '0;
        apply(100, mk(1'b0, 2'd1, 32'h20, 32'h0, 0, 3, 32'h0000_00DD, 3, 32'h0000_00DD, 1'b0));
        apply(101, mk(1'b0, 2'd1, 32'h21, 32'h0, 0, 3, 32'h0000_0000, 3, 32'h0000_0000, 1'b0));
        apply(102, mk(1'b0, 2'd3, 32'h20, 32'h0, 0, 6, 32'h0000_00DD, 6, 32'h0000_00DD, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
